// File: rtl/accel_pkg.sv
// Shared accelerator definitions: row and lane geometry plus the activation lane mode.
// Used by the bias adder and by the activation FIFO.
package accel_pkg;

  localparam int INT_LANE_W = 8;
  localparam int FP_LANE_W  = 16;
  localparam int ROW_W      = 64;

  localparam int INT_LANES = ROW_W / INT_LANE_W;
  localparam int FP_LANES  = ROW_W / FP_LANE_W;

  typedef enum logic {
    ACT_MODE_INT8 = 1'b0,
    ACT_MODE_FP16 = 1'b1
  } act_mode_e;

endpackage

// File: rtl/activation_fifo_relu_row.sv
// Combinational ReLU over one 64-bit row: a lane with its sign bit set becomes zero.
// In fp16 mode this also clears -0.0 and negative NaN.
module relu_row
  import accel_pkg::*;
(
  input  logic [ROW_W-1:0] in_row,
  input  logic             float,
  output logic [ROW_W-1:0] out_row
);

  act_mode_e mode;

  assign mode = act_mode_e'(float);

  always_comb begin
    out_row = in_row;
    if (mode == ACT_MODE_FP16) begin
      for (int unsigned i = 0; i < FP_LANES; i++) begin
        if (in_row[i*FP_LANE_W + FP_LANE_W - 1]) begin
          out_row[i*FP_LANE_W +: FP_LANE_W] = '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < INT_LANES; i++) begin
        if (in_row[i*INT_LANE_W + INT_LANE_W - 1]) begin
          out_row[i*INT_LANE_W +: INT_LANE_W] = '0;
        end
      end
    end
  end

endmodule

// File: rtl/activation_fifo.sv
// Activation FIFO: optional ReLU applied on entry, rows then queued in a DEPTH-entry buffer.
// The head row is presented with valid/ready handshakes on both sides.
module activation_fifo
  import accel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  input  logic [63:0]              in_data,
  input  logic                     float,
  input  logic                     act_en,
  input  logic                     flush,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [63:0]              out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ROW_W-1:0] mem_q [DEPTH];

  logic [ROW_W-1:0] relu_data;
  logic [ROW_W-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;

  relu_row u_relu_row (
    .in_row  (in_data),
    .float   (float),
    .out_row (relu_data)
  );

  assign wr_data   = act_en ? relu_data : in_data;
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // A flush discards any handshake in the same cycle.
  assign wr_en = in_valid & in_ready & ~flush;
  assign rd_en = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty-state output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (n_rst && wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_activation_fifo.sv
// Directed bench for activation_fifo: ReLU lanes, full/empty, wrap, flush and reset.
module tb_activation_fifo;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        float_mode;
  logic        act_en;
  logic        flush;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  activation_fifo #(.DEPTH(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .float     (float_mode),
    .act_en    (act_en),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [63:0] data, input logic fm, input logic ae);
    in_valid   = 1'b1;
    in_data    = data;
    float_mode = fm;
    act_en     = ae;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic pop_row();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic accepted;
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; float_mode = 1'b0;
    act_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step();
    step();

    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'h0);
    n_rst = 1'b1;
    step();

    // int8 ReLU
    write_row(64'h807F_FF01_0090_10C3, 1'b0, 1'b1);
    check("int_relu", out_data, 64'h007F_0001_0000_1000);
    check("int_count", 64'(count), 64'd1);
    check("int_valid", 64'(out_valid), 64'd1);
    pop_row();
    check("int_pop_count", 64'(count), 64'd0);

    // fp16 ReLU then pass-through
    write_row(64'hBC00_3C00_8000_7E00, 1'b1, 1'b1);
    write_row(64'hBC00_3C00_8000_7E00, 1'b1, 1'b0);
    check("fp_relu", out_data, 64'h0000_3C00_0000_7E00);
    pop_row();
    check("fp_pass", out_data, 64'hBC00_3C00_8000_7E00);
    write_row(64'h8081_FF7F_0102_90A0, 1'b0, 1'b0);
    pop_row();
    check("int_pass", out_data, 64'h8081_FF7F_0102_90A0);
    pop_row();
    check("fp_empty", 64'(out_valid), 64'd0);

    // fill, hold a ninth row, drain in order
    for (int i = 1; i <= 8; i++) write_row(64'(i), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = 64'd9;
    step();
    check("full_no_write", 64'(count), 64'd8);
    check("full_head", out_data, 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      check("drain_order", out_data, 64'(i));
      accepted = in_valid & in_ready;
      step();
      if (accepted) in_valid = 1'b0;
      if (i == 1) check("full_pop_count", 64'(count), 64'd7);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("drain_empty", 64'(count), 64'd0);

    // steady write+pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) write_row(64'(100 + i), 1'b0, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 64'(103 + k);
      check("stream_order", out_data, 64'(100 + k));
      step();
      check("stream_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stream_tail", out_data, 64'(120 + k));
      step();
    end
    out_ready = 1'b0;
    check("stream_empty", 64'(count), 64'd0);

    // flush with simultaneous write and pop
    for (int i = 0; i < 5; i++) write_row(64'(200 + i), 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'd999; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    write_row(64'd300, 1'b0, 1'b0);
    check("post_flush_head", out_data, 64'd300);
    check("post_flush_count", 64'(count), 64'd1);
    pop_row();

    // reset mid-stream with in_valid high
    for (int i = 0; i < 4; i++) write_row(64'(400 + i), 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd4);
    n_rst = 1'b0; in_valid = 1'b1; in_data = 64'd555;
    step();
    n_rst = 1'b1; in_valid = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", out_data, 64'h0);

    // pop when empty has no effect
    pop_row();
    check("empty_pop_count", 64'(count), 64'd0);
    write_row(64'hFEED, 1'b0, 1'b0);
    check("after_empty_pop", out_data, 64'hFEED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/activation_fifo.md
ACTIVATION_FIFO -- requirements
Module: activation_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of 64-bit FIFO entries; power of two, 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  in_data holds a bias-adder result row.
REQ-005 in_data  input  64  bias_outputs row from the bias adder.
REQ-006 float  input  1  0: eight signed int8 lanes; 1: four fp16 lanes; sampled with in_data.
REQ-007 act_en  input  1  1: apply ReLU; 0: pass-through; sampled with in_data.
REQ-008 flush  input  1  synchronous clear of FIFO contents.
REQ-009 in_ready  output  1  block can accept a row this cycle.
REQ-010 out_valid  output  1  out_data holds the FIFO head row.
REQ-011 out_data  output  64  activated row at FIFO head.
REQ-012 out_ready  input  1  consumer takes the head row this cycle.
REQ-013 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 Write handshake: a row is written on a rising edge when in_valid && in_ready.
REQ-015 Read handshake: the head is popped on a rising edge when out_valid && out_ready.
REQ-016 in_ready = (count < DEPTH); out_valid = (count != 0); both combinational from state.
REQ-017 Activation is applied before storage; each entry holds the activated row only.
REQ-018 Int mode with act_en=1: each 8-bit lane with bit 7 set becomes 8'h00; other lanes unchanged.
REQ-019 Float mode with act_en=1: each 16-bit lane with bit 15 set becomes 16'h0000 (including -0.0 and negative NaN).
REQ-020 act_en=0: row stored bit-exact regardless of float.
REQ-021 Latency: a row written at edge N is visible on out_data with out_valid=1 after edge N when FIFO was empty; no same-cycle bypass.
REQ-022 Full with simultaneous pop: in_ready stays 0 that cycle; no write occurs; count decrements.
REQ-023 Simultaneous write and pop when 0<count<DEPTH: count unchanged, both pointers advance.
REQ-024 Pointers wrap modulo DEPTH; ordering is strict FIFO across wrap.
REQ-025 out_data is held stable while out_valid=1 and out_ready=0.
REQ-026 flush=1: at next edge count=0, pointers=0; any write or pop in the same cycle is discarded.
REQ-027 Pop when empty and write when full have no effect on state.

Reset
REQ-028 n_rst=0 at a rising edge: count=0, read/write pointers=0; in_ready=1, out_valid=0 after that edge.
REQ-029 out_data after reset = 64'h0 until the first write; storage array itself is not reset.
REQ-030 Reset mid-stream discards all stored rows; reset has priority over flush, write and pop.

Structure
REQ-031 Lane-width constants (INT_LANE_W=8, FP_LANE_W=16, ROW_W=64) and the activation-mode type reside in the shared accelerator package used by the bias adder.
REQ-032 One sub-module, relu_row: combinational 64-bit ReLU taking row and float, instantiated once ahead of the storage write port.
REQ-033 Storage is a register array of DEPTH x ROW_W; pointers are $clog2(DEPTH) bits.

Verification
REQ-034 Reset, then write int row 64'h80_7F_FF_01_00_90_10_C3 with act_en=1 -> out_data 64'h00_7F_00_01_00_00_10_00 one edge later, count=1.
REQ-035 Float row 64'hBC00_3C00_8000_7E00 with act_en=1 -> 64'h0000_3C00_0000_7E00; same row act_en=0 -> unchanged.
REQ-036 Write 8 rows 1..8 with out_ready=0 -> count=8, in_ready=0; 9th row held on in_valid not accepted; then drain -> rows 1..8 in order, then row 9.
REQ-037 Continuous write+pop at count=3 for 20 cycles -> count stays 3, pointers wrap, output order matches input order.
REQ-038 count=5, assert flush together with in_valid and out_ready -> count=0, out_valid=0 next cycle, next written row is first out.
REQ-039 count=4, n_rst=0 for one edge while in_valid=1 -> count=0, out_valid=0, in_ready=1 after that edge.
